// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single-precision field widths,
// canonical special encodings, operand classes and the divide issue bundle.
package fpu_pkg;

    localparam int FP_W   = 32;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [FP_W-1:0] QNAN    = 32'h7FC00000;
    localparam logic [FP_W-1:0] POS_INF = 32'h7F800000;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORMAL,
        FP_INF,
        FP_NAN
    } fp_class_t;

    typedef struct packed {
        logic              sign;
        logic [9:0]        exp;
        logic [FRAC_W:0]   mant1;
        logic [FRAC_W:0]   mant2;
        logic              special;
        logic [FP_W-1:0]   special_value;
    } div_op_t;

endpackage

// File: rtl/fpu_unpack.sv
// Combinational classify/unpack of one single-precision operand.
// Denormals classify as zero; the sign is passed through unchanged.
module fpu_unpack
    import fpu_pkg::*;
(
    input  logic [FP_W-1:0]   fp,
    output logic              sign,
    output logic [EXP_W-1:0]  exp,
    output logic [FRAC_W:0]   mant,
    output fp_class_t         cls
);

    logic [FRAC_W-1:0] frac;

    assign sign = fp[FP_W-1];
    assign exp  = fp[FP_W-2:FRAC_W];
    assign frac = fp[FRAC_W-1:0];
    assign mant = {1'b1, frac};

    // Classify from the exponent and fraction fields
    always_comb begin
        cls = FP_NORMAL;
        if (exp == '1) begin
            cls = (frac != '0) ? FP_NAN : FP_INF;
        end else if (exp == '0) begin
            cls = FP_ZERO;
        end
    end

endmodule

// File: rtl/fpu_div_operand_stage.sv
// Divide operand-issue stage: unpacks two operands, resolves special
// cases, and issues through an output register backed by one skid entry.
module fpu_div_operand_stage
    import fpu_pkg::*;
#(
    parameter int SPECIAL_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FP_W-1:0]          floating1_in,
    input  logic [FP_W-1:0]          floating2_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sign,
    output logic [9:0]               out_exp,
    output logic [FRAC_W:0]          out_mant1,
    output logic [FRAC_W:0]          out_mant2,
    output logic                     out_special,
    output logic [FP_W-1:0]          out_special_value,
    output logic [SPECIAL_CNT_W-1:0] special_count
);

    logic             sign1, sign2, s;
    logic [EXP_W-1:0] exp1, exp2;
    logic [FRAC_W:0]  mant1, mant2;
    fp_class_t        cls1, cls2;
    div_op_t          unpacked;

    div_op_t out_reg, skid_reg, out_next, skid_next;
    logic    skid_valid, out_valid_next, skid_valid_next;
    logic    in_fire, out_fire;

    fpu_unpack u_unpack1 (
        .fp   (floating1_in),
        .sign (sign1),
        .exp  (exp1),
        .mant (mant1),
        .cls  (cls1)
    );

    fpu_unpack u_unpack2 (
        .fp   (floating2_in),
        .sign (sign2),
        .exp  (exp2),
        .mant (mant2),
        .cls  (cls2)
    );

    assign s = sign1 ^ sign2;

    // Build the issue bundle, resolving special cases in priority order
    always_comb begin
        unpacked               = '0;
        unpacked.sign          = s;
        unpacked.exp           = {2'b00, exp1} - {2'b00, exp2} + 10'(BIAS);
        unpacked.mant1         = mant1;
        unpacked.mant2         = mant2;
        unpacked.special       = 1'b1;
        unpacked.special_value = '0;
        if (cls1 == FP_NAN || cls2 == FP_NAN) begin
            unpacked.special_value = QNAN;
        end else if ((cls1 == FP_INF && cls2 == FP_INF) ||
                     (cls1 == FP_ZERO && cls2 == FP_ZERO)) begin
            unpacked.special_value = QNAN;
        end else if (cls1 == FP_INF || cls2 == FP_ZERO) begin
            unpacked.special_value = {s, POS_INF[FP_W-2:0]};
        end else if (cls1 == FP_ZERO || cls2 == FP_INF) begin
            unpacked.special_value = {s, {(FP_W-1){1'b0}}};
        end else begin
            unpacked.special = 1'b0;
        end
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Skid control: refill output from skid first, else from the input
    always_comb begin
        out_next        = out_reg;
        skid_next       = skid_reg;
        out_valid_next  = out_valid;
        skid_valid_next = skid_valid;
        if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_next        = skid_reg;
                out_valid_next  = 1'b1;
                skid_valid_next = 1'b0;
            end else if (in_fire) begin
                out_next       = unpacked;
                out_valid_next = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (in_fire) begin
            skid_next       = unpacked;
            skid_valid_next = 1'b1;
        end
    end

    // State registers, registered ready and saturating special counter
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg       <= '0;
            skid_reg      <= '0;
            out_valid     <= 1'b0;
            skid_valid    <= 1'b0;
            in_ready      <= 1'b0;
            special_count <= '0;
        end else begin
            out_reg    <= out_next;
            skid_reg   <= skid_next;
            out_valid  <= out_valid_next;
            skid_valid <= skid_valid_next;
            in_ready   <= !skid_valid_next;
            if (out_fire && out_reg.special && special_count != '1) begin
                special_count <= special_count + 1'b1;
            end
        end
    end

    assign out_sign          = out_reg.sign;
    assign out_exp           = out_reg.exp;
    assign out_mant1         = out_reg.mant1;
    assign out_mant2         = out_reg.mant2;
    assign out_special       = out_reg.special;
    assign out_special_value = out_reg.special_value;

endmodule

// File: tb/tb_fpu_div_operand_stage.sv
// Directed self-checking bench for the divide operand-issue stage,
// including a narrow-counter instance to exercise saturation.
module tb_fpu_div_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] floating1_in;
    logic [31:0] floating2_in;

    logic        in_ready, out_valid, out_sign, out_special;
    logic [9:0]  out_exp;
    logic [23:0] out_mant1, out_mant2;
    logic [31:0] out_special_value;
    logic [15:0] special_count;

    logic        in_ready2, out_valid2, out_sign2, out_special2;
    logic [9:0]  out_exp2;
    logic [23:0] out_mant1_2, out_mant2_2;
    logic [31:0] out_special_value2;
    logic [1:0]  special_count2;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fpu_div_operand_stage #(.SPECIAL_CNT_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .floating1_in      (floating1_in),
        .floating2_in      (floating2_in),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_sign          (out_sign),
        .out_exp           (out_exp),
        .out_mant1         (out_mant1),
        .out_mant2         (out_mant2),
        .out_special       (out_special),
        .out_special_value (out_special_value),
        .special_count     (special_count)
    );

    fpu_div_operand_stage #(.SPECIAL_CNT_W(2)) dut_sat (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready2),
        .floating1_in      (floating1_in),
        .floating2_in      (floating2_in),
        .out_valid         (out_valid2),
        .out_ready         (out_ready),
        .out_sign          (out_sign2),
        .out_exp           (out_exp2),
        .out_mant1         (out_mant1_2),
        .out_mant2         (out_mant2_2),
        .out_special       (out_special2),
        .out_special_value (out_special_value2),
        .special_count     (special_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        in_valid     = 1'b1;
        floating1_in = a;
        floating2_in = b;
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        floating1_in = '0;
        floating2_in = '0;

        @(negedge clk);
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(special_count), 32'd0);
        check("rst_spval", out_special_value, 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 3.0 / 2.0
        drive(32'h40400000, 32'h40000000);
        step();
        check("d1_valid", 32'(out_valid), 32'd1);
        check("d1_sign", 32'(out_sign), 32'd0);
        check("d1_exp", 32'(out_exp), 32'd127);
        check("d1_mant1", 32'(out_mant1), 32'hC00000);
        check("d1_mant2", 32'(out_mant2), 32'h800000);
        check("d1_special", 32'(out_special), 32'd0);

        // -4.0 / 4.0
        drive(32'hC0800000, 32'h40800000);
        step();
        check("d2_sign", 32'(out_sign), 32'd1);
        check("d2_exp", 32'(out_exp), 32'd127);
        check("d2_mant1", 32'(out_mant1), 32'h800000);
        check("d2_mant2", 32'(out_mant2), 32'h800000);
        check("d2_special", 32'(out_special), 32'd0);

        // 1.0 / 0.0
        drive(32'h3F800000, 32'h00000000);
        step();
        check("div0_special", 32'(out_special), 32'd1);
        check("div0_value", out_special_value, 32'h7F800000);
        check("div0_count", 32'(special_count), 32'd0);

        drive(32'h00000000, 32'h00000000);
        step();
        check("zz_value", out_special_value, 32'h7FC00000);

        drive(32'h7F800000, 32'h7F800000);
        step();
        check("ii_value", out_special_value, 32'h7FC00000);

        drive(32'h00000000, 32'h3F800000);
        step();
        check("z1_value", out_special_value, 32'h00000000);
        check("z1_special", 32'(out_special), 32'd1);

        drive(32'hC1FC0000, 32'h7F800000);
        step();
        check("fi_value", out_special_value, 32'h80000000);

        drive(32'h00000001, 32'h3F800000);
        step();
        check("denorm_special", 32'(out_special), 32'd1);
        check("denorm_value", out_special_value, 32'h00000000);
        check("count5", 32'(special_count), 32'd5);
        check("sat_count", 32'(special_count2), 32'd3);

        in_valid = 1'b0;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("count6", 32'(special_count), 32'd6);
        check("sat_hold", 32'(special_count2), 32'd3);

        // Backpressure: A held, B in skid, C stalled
        out_ready = 1'b0;
        drive(32'h40400000, 32'h40000000);
        step();
        check("bp_a_valid", 32'(out_valid), 32'd1);
        check("bp_a_ready", 32'(in_ready), 32'd1);
        drive(32'hC0800000, 32'h40800000);
        step();
        check("bp_b_ready", 32'(in_ready), 32'd0);
        check("bp_hold_a", 32'(out_mant1), 32'hC00000);
        drive(32'h3F800000, 32'h40000000);
        step();
        check("bp_c_ready", 32'(in_ready), 32'd0);
        check("bp_hold_a2", 32'(out_mant1), 32'hC00000);
        check("bp_hold_sign", 32'(out_sign), 32'd0);
        out_ready = 1'b1;
        step();
        check("bp_b_valid", 32'(out_valid), 32'd1);
        check("bp_b_sign", 32'(out_sign), 32'd1);
        check("bp_b_mant1", 32'(out_mant1), 32'h800000);
        check("bp_ready_up", 32'(in_ready), 32'd1);
        step();
        check("bp_c_valid", 32'(out_valid), 32'd1);
        check("bp_c_exp", 32'(out_exp), 32'd126);
        check("bp_c_sign", 32'(out_sign), 32'd0);
        in_valid = 1'b0;
        step();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Reset with both entries full
        out_ready = 1'b0;
        drive(32'h3F800000, 32'h00000000);
        step();
        drive(32'h40400000, 32'h40000000);
        step();
        in_valid = 1'b0;
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_count", 32'(special_count), 32'd6);
        rst = 1'b1;
        step();
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_count", 32'(special_count), 32'd0);
        check("mrst_ready", 32'(in_ready), 32'd0);
        check("mrst_mant1", 32'(out_mant1), 32'h0);
        check("mrst_sat", 32'(special_count2), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        check("mrst_ready_up", 32'(in_ready), 32'd1);
        check("mrst_no_stale", 32'(out_valid), 32'd0);
        step();
        check("mrst_no_stale2", 32'(out_valid), 32'd0);
        check("mrst_count2", 32'(special_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
